// File: rtl/data_mem_unit_pkg.sv
// data_mem_unit_pkg: access-size and FSM state encodings shared by the data memory files
package data_mem_unit_pkg;
  localparam logic [1:0] MEM_SZ_BYTE = 2'd0;
  localparam logic [1:0] MEM_SZ_HALF = 2'd1;
  localparam logic [1:0] MEM_SZ_WORD = 2'd2;
  localparam logic [1:0] MEM_SZ_DOUBLE = 2'd3;
  typedef enum logic [1:0] {MEM_ST_INIT, MEM_ST_IDLE, MEM_ST_WAIT, MEM_ST_RESP} mem_state_t;
  function automatic int unsigned size_bytes(input logic [1:0] sz);
    return 32'd1 << sz;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: big-endian byte-lane steering for stores and extension of loads within one bus word
module mem_lane_align
  import data_mem_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]                      size,
  input  logic                            uns,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] off,
  input  logic [DATA_WIDTH-1:0]           wdata,
  input  logic [DATA_WIDTH-1:0]           raw,
  output logic [DATA_WIDTH/8-1:0]         be,
  output logic [DATA_WIDTH-1:0]           wshift,
  output logic [DATA_WIDTH-1:0]           rdata
);
  localparam int BB = DATA_WIDTH / 8;
  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  int nb, sh;
  logic [DATA_WIDTH-1:0] mask, val, top;
  // byte offset 0 is the most significant lane, so an access ending at the last byte needs no shift
  always_comb begin
    nb = int'(size_bytes(size));
    sh = (int'(off) + nb > BB) ? 0 : BB - int'(off) - nb;
    mask = (nb >= BB) ? '1 : (ONE << (8 * nb)) - ONE;
    top = mask & ~(mask >> 1);
    val = (raw >> (8 * sh)) & mask;
    rdata = (!uns && |(val & top)) ? val | ~mask : val;
    wshift = (wdata & mask) << (8 * sh);
    for (int k = 0; k < BB; k++) be[k] = (k >= sh) && (k < sh + nb);
  end
endmodule

// File: rtl/data_mem_unit.sv
// data_mem_unit: byte-addressed big-endian data memory with valid/ready requests, wait states and cleared contents
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  init_busy
);
  localparam int BB = DATA_WIDTH / 8;
  localparam int OW = $clog2(BB);
  localparam int WORDS = DEPTH_BYTES / BB;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
  localparam logic [3:0] WLOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  mem_state_t state, state_n;
  logic [IW-1:0] cnt, idx;
  logic [3:0] wcnt;
  logic c_write, c_uns, a_write, a_uns, accept, go_resp, err;
  logic [1:0] c_size, a_size;
  logic [ADDR_WIDTH-1:0] c_addr, a_addr;
  logic [ADDR_WIDTH:0] last_byte;
  logic [DATA_WIDTH-1:0] c_wdata, a_wdata, raw, wshift, ldata;
  logic [BB-1:0] be;
  logic [DATA_WIDTH-1:0] mem [WORDS];
  assign req_ready = state == MEM_ST_IDLE;
  assign init_busy = state == MEM_ST_INIT;
  assign accept = req_valid && req_ready;
  // without wait states the access happens on the accepting edge, so the live request bypasses capture
  assign a_write = req_ready ? req_write : c_write;
  assign a_uns = req_ready ? req_unsigned : c_uns;
  assign a_size = req_ready ? req_size : c_size;
  assign a_addr = req_ready ? req_addr : c_addr;
  assign a_wdata = req_ready ? req_wdata : c_wdata;
  assign go_resp = (state == MEM_ST_IDLE && accept && WAIT_STATES == 0) || (state == MEM_ST_WAIT && wcnt == 4'd0);
  assign idx = a_addr[OW +: IW];
  assign raw = mem[idx];
  assign last_byte = {1'b0, a_addr} + (ADDR_WIDTH + 1)'(size_bytes(a_size) - 1);
  assign err = (a_size == MEM_SZ_DOUBLE && DATA_WIDTH == 32)
    || (a_addr[2:0] & 3'(size_bytes(a_size) - 1)) != 3'd0
    || last_byte >= (ADDR_WIDTH + 1)'(DEPTH_BYTES);
  mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .size(a_size),
    .uns(a_uns),
    .off(a_addr[OW-1:0]),
    .wdata(a_wdata),
    .raw(raw),
    .be(be),
    .wshift(wshift),
    .rdata(ldata)
  );
  always_comb begin
    state_n = state == MEM_ST_INIT ? (cnt == LAST ? MEM_ST_IDLE : MEM_ST_INIT)
      : state == MEM_ST_IDLE ? (accept ? (WAIT_STATES > 0 ? MEM_ST_WAIT : MEM_ST_RESP) : MEM_ST_IDLE)
      : state == MEM_ST_WAIT ? (wcnt == 4'd0 ? MEM_ST_RESP : MEM_ST_WAIT)
      : MEM_ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= MEM_ST_INIT;
      cnt <= '0;
      wcnt <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      state <= state_n;
      rsp_valid <= go_resp;
      if (init_busy) cnt <= cnt + 1'b1;
      if (accept) begin
        c_write <= req_write;
        c_uns <= req_unsigned;
        c_size <= req_size;
        c_addr <= req_addr;
        c_wdata <= req_wdata;
        wcnt <= WLOAD;
      end else if (state == MEM_ST_WAIT) wcnt <= wcnt - 1'b1;
      if (go_resp) begin
        rsp_rdata <= (err || a_write) ? '0 : ldata;
        rsp_error <= err;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst && init_busy) mem[cnt] <= '0;
    else if (rst && go_resp && a_write && !err)
      for (int k = 0; k < BB; k++) if (be[k]) mem[idx][8*k +: 8] <= wshift[8*k +: 8];
  end
endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: checks a zero-wait and a three-wait instance against a byte-array memory model
module tb_data_mem_unit;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0] valid = '0, ready, rv, re, busy;
  logic [31:0] rdata [2];
  int checks = 0, fails = 0, cyc = 0;
  logic [7:0] mdl [2][1024];
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_unit #(.WAIT_STATES(0)) d0 (
    .clk(clk), .rst(rst), .req_valid(valid[0]), .req_ready(ready[0]), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv[0]), .rsp_rdata(rdata[0]), .rsp_error(re[0]), .init_busy(busy[0])
  );
  data_mem_unit #(.WAIT_STATES(3)) d3 (
    .clk(clk), .rst(rst), .req_valid(valid[1]), .req_ready(ready[1]), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv[1]), .rsp_rdata(rdata[1]), .rsp_error(re[1]), .init_busy(busy[1])
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int d = 0; d < 2; d++) for (int i = 0; i < 1024; i++) mdl[d][i] = 8'h00;
  endtask

  // byte-array reference: N bytes starting at a, first byte most significant
  task automatic mdl_op(int d, bit w, bit [1:0] sz, bit u, bit [31:0] a, bit [31:0] wd,
                        output bit [31:0] rd, output bit er);
    longint n, v;
    n = longint'(1) << sz;
    v = 0;
    rd = '0;
    er = (sz == 2'd3) || (longint'(a) % n != 0) || (longint'(a) + n - 1 >= 1024);
    if (er) return;
    for (longint i = 0; i < n; i++) begin
      if (w) mdl[d][longint'(a) + i] = 8'(longint'(wd) >> (8 * (n - 1 - i)));
      else v = (v << 8) | longint'(mdl[d][longint'(a) + i]);
    end
    if (!w && !u && v[8*n-1]) v = v - (longint'(1) << (8 * n));
    if (!w) rd = 32'(v);
  endtask

  task automatic reset_chk(string name);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d ready", name, d), 32'(ready[d]), 32'd0);
      chk($sformatf("%s d%0d rsp_valid", name, d), 32'(rv[d]), 32'd0);
      chk($sformatf("%s d%0d rdata", name, d), rdata[d], 32'd0);
      chk($sformatf("%s d%0d error", name, d), 32'(re[d]), 32'd0);
      chk($sformatf("%s d%0d busy", name, d), 32'(busy[d]), 32'd1);
    end
  endtask

  // call at the negedge where rst is raised; counts edges until each instance leaves the clear phase
  task automatic wait_init(string name, output bit rsp_seen);
    int c [2];
    int t;
    c[0] = -1;
    c[1] = -1;
    t = 0;
    rsp_seen = 1'b0;
    while ((c[0] < 0 || c[1] < 0) && t < 1000) begin
      @(negedge clk);
      t++;
      rsp_seen |= rv[1] | rv[0];
      for (int d = 0; d < 2; d++) if (c[d] < 0 && !busy[d]) c[d] = t;
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d init cycles", name, d), c[d], 32'd256);
      chk($sformatf("%s d%0d ready after init", name, d), 32'(ready[d]), 32'd1);
    end
  endtask

  task automatic xact(int d, bit w, bit [1:0] sz, bit u, bit [31:0] a, bit [31:0] wd, string name,
                      output logic [31:0] rd, output logic er);
    int t, lat;
    bit rdy_bad;
    t = 0;
    while (!ready[d] && t < 1000) begin
      @(negedge clk);
      t++;
    end
    req_write = w;
    req_size = sz;
    req_unsigned = u;
    req_addr = a;
    req_wdata = wd;
    valid[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[d] = 1'b0;
    lat = 1;
    rdy_bad = 1'b0;
    while (!rv[d] && lat < 100) begin
      rdy_bad |= ready[d];
      @(negedge clk);
      lat++;
    end
    rdy_bad |= ready[d];
    chk({name, " latency"}, lat, d == 1 ? 32'd4 : 32'd1);
    chk({name, " ready low"}, 32'(rdy_bad), 32'd0);
    rd = rdata[d];
    er = re[d];
    @(negedge clk);
    chk({name, " pulse"}, 32'(rv[d]), 32'd0);
  endtask

  task automatic run(int d, bit w, bit [1:0] sz, bit u, bit [31:0] a, bit [31:0] wd, string name);
    logic [31:0] rd;
    logic er;
    bit [31:0] mrd;
    bit mer;
    xact(d, w, sz, u, a, wd, name, rd, er);
    mdl_op(d, w, sz, u, a, wd, mrd, mer);
    chk({name, " rdata"}, rd, mrd);
    chk({name, " error"}, 32'(er), 32'(mer));
  endtask

  typedef struct {
    bit w;
    bit [1:0] sz;
    bit u;
    bit [31:0] a;
    bit [31:0] wd;
    bit [31:0] exp;
    bit err;
  } vec_t;
  vec_t tbl[$];

  initial begin
    logic [31:0] rd;
    logic er;
    bit [31:0] mrd, a, wd;
    bit mer, seen, w, u;
    bit [1:0] sz;
    int acc[$];
    int t;
    tbl.push_back('{0, 2, 0, 32'h10, 0, 32'h0, 0});
    tbl.push_back('{1, 2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0});
    tbl.push_back('{0, 0, 0, 32'h10, 0, 32'hFFFFFFDE, 0});
    tbl.push_back('{0, 0, 0, 32'h11, 0, 32'hFFFFFFAD, 0});
    tbl.push_back('{0, 0, 0, 32'h12, 0, 32'hFFFFFFBE, 0});
    tbl.push_back('{0, 0, 0, 32'h13, 0, 32'hFFFFFFEF, 0});
    tbl.push_back('{0, 0, 1, 32'h10, 0, 32'h000000DE, 0});
    tbl.push_back('{1, 2, 0, 32'h20, 32'hAABBCCDD, 32'h0, 0});
    tbl.push_back('{1, 1, 0, 32'h22, 32'hFFFF1234, 32'h0, 0});
    tbl.push_back('{0, 2, 0, 32'h20, 0, 32'hAABB1234, 0});
    tbl.push_back('{0, 1, 0, 32'h20, 0, 32'hFFFFAABB, 0});
    tbl.push_back('{0, 1, 1, 32'h22, 0, 32'h00001234, 0});
    tbl.push_back('{1, 2, 0, 32'h13, 32'h11111111, 32'h0, 1});
    tbl.push_back('{0, 1, 0, 32'h21, 0, 32'h0, 1});
    tbl.push_back('{0, 2, 0, 32'h10, 0, 32'hDEADBEEF, 0});
    tbl.push_back('{0, 2, 0, 32'h3FE, 0, 32'h0, 1});
    tbl.push_back('{0, 2, 0, 32'h3FC, 0, 32'h0, 0});
    tbl.push_back('{0, 3, 0, 32'h18, 0, 32'h0, 1});
    tbl.push_back('{1, 0, 0, 32'h3FF, 32'h0000005A, 32'h0, 0});
    tbl.push_back('{0, 0, 1, 32'h3FF, 0, 32'h0000005A, 0});
    tbl.push_back('{0, 0, 0, 32'h400, 0, 32'h0, 1});
    tbl.push_back('{0, 0, 0, 32'hFFFFFFFF, 0, 32'h0, 1});
    tbl.push_back('{1, 1, 0, 32'h3FE, 32'h0000807F, 32'h0, 0});
    tbl.push_back('{0, 1, 0, 32'h3FE, 0, 32'hFFFF807F, 0});
    mdl_clear();
    repeat (3) @(negedge clk);
    reset_chk("reset");
    rst = 1'b1;
    wait_init("init", seen);
    for (int i = 0; i < 8; i++) run(0, 0, 2'd2, 0, 32'($urandom_range(0, 255)) << 2, 0, $sformatf("zero%0d", i));
    foreach (tbl[i]) begin
      xact(0, tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, $sformatf("vec%0d", i), rd, er);
      mdl_op(0, tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, mrd, mer);
      chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp);
      chk($sformatf("vec%0d error", i), 32'(er), 32'(tbl[i].err));
    end
    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(0, 3));
      w = ($urandom % 3) == 0;
      u = 1'($urandom % 2);
      a = ($urandom % 4 == 0) ? 32'($urandom_range(960, 1090)) : 32'($urandom_range(0, 63));
      if ($urandom % 4 != 0) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom % 25 == 0) a = 32'hFFFFFFF8 | 32'($urandom % 8);
      wd = $urandom;
      run(i % 5 == 0 ? 1 : 0, w, sz, u, a, wd, $sformatf("rand%0d", i));
    end
    run(1, 1, 2'd2, 0, 32'h40, 32'hCAFEF00D, "ws3 store");
    req_write = 1'b0;
    req_size = 2'd2;
    req_unsigned = 1'b0;
    req_addr = 32'h40;
    valid[1] = 1'b1;
    t = 0;
    while (acc.size() < 3 && t < 100) begin
      if (ready[1]) acc.push_back(cyc);
      @(negedge clk);
      t++;
    end
    valid[1] = 1'b0;
    chk("b2b accepts", acc.size(), 32'd3);
    if (acc.size() >= 3) begin
      chk("b2b gap1", acc[1] - acc[0], 32'd5);
      chk("b2b gap2", acc[2] - acc[1], 32'd5);
    end
    repeat (6) @(negedge clk);
    run(1, 0, 2'd2, 0, 32'h40, 0, "ws3 load");
    req_write = 1'b1;
    req_size = 2'd0;
    req_addr = 32'h8;
    req_wdata = 32'h55;
    valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[1] = 1'b0;
    @(negedge clk);
    seen = rv[1];
    rst = 1'b0;
    @(negedge clk);
    seen |= rv[1];
    reset_chk("abort");
    @(negedge clk);
    seen |= rv[1];
    rst = 1'b1;
    wait_init("reinit", mer);
    chk("abort no rsp", 32'(seen | mer), 32'd0);
    mdl_clear();
    xact(1, 0, 2'd0, 1, 32'h8, 0, "abort byte", rd, er);
    chk("abort byte rdata", rd, 32'd0);
    run(1, 0, 2'd2, 0, 32'h8, 0, "abort word");
    run(0, 0, 2'd2, 0, 32'h10, 0, "cleared d0");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
